// File: rtl/usr_pkg.sv
// ============================================================================
// Module  : usr_pkg
// Brief   : Shared mode encodings and receiver state type for usr_deserializer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package usr_pkg;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } usr_state_t;

endpackage

`default_nettype wire

// File: rtl/usr_sipo_core.sv
// ============================================================================
// Module  : usr_sipo_core
// Brief   : Shift register, bit counter and direction latch; flags completion.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module usr_sipo_core
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             serin,
    input  logic             servalid,
    output logic             done,
    output logic [WIDTH-1:0] word,
    output logic             dirchange
);

    localparam int             CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  C_FULL = CW'(WIDTH);

    usr_state_t       r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_bitcnt;
    logic             r_dir;

    logic             w_capmode;
    logic             w_mdir;
    logic             w_cap;
    logic [WIDTH-1:0] w_base_sh;
    logic [CW-1:0]    w_base_cnt;
    logic [WIDTH-1:0] w_next_sh;
    logic [CW-1:0]    w_next_cnt;

    always_comb begin
        w_capmode  = (mode == MODE_SHR) || (mode == MODE_SHL);
        w_mdir     = (mode == MODE_SHL);
        w_cap      = w_capmode && servalid;
        // A direction change abandons the pending word; the current bit restarts.
        dirchange  = w_capmode && (r_state == SHIFT) && (w_mdir != r_dir);
        w_base_sh  = dirchange ? '0 : r_shreg;
        w_base_cnt = dirchange ? '0 : r_bitcnt;
        w_next_sh  = w_mdir ? {w_base_sh[WIDTH-2:0], serin}
                            : {serin, w_base_sh[WIDTH-1:1]};
        w_next_cnt = w_base_cnt + CW'(1);
        done       = w_cap && (w_next_cnt == C_FULL);
        word       = w_next_sh;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_dir    <= 1'b0;
        end else if (mode == MODE_IDLE) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
        end else if (w_capmode) begin
            if (w_cap) begin
                if (w_base_cnt == '0) begin
                    r_dir <= w_mdir;
                end
                if (done) begin
                    r_state  <= IDLE;
                    r_shreg  <= '0;
                    r_bitcnt <= '0;
                end else begin
                    r_state  <= SHIFT;
                    r_shreg  <= w_next_sh;
                    r_bitcnt <= w_next_cnt;
                end
            end else if (dirchange) begin
                r_state  <= IDLE;
                r_shreg  <= '0;
                r_bitcnt <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/usr_deserializer.sv
// ============================================================================
// Module  : usr_deserializer
// Brief   : Serial-to-parallel receiver with valid/ready output and error flags.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module usr_deserializer
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             serin,
    input  logic             servalid,
    output logic [WIDTH-1:0] dataout,
    output logic             doutvalid,
    input  logic             doutready,
    output logic             overrun,
    output logic             frameerr,
    input  logic             clrerr
);

    logic             w_done;
    logic [WIDTH-1:0] w_word;
    logic             w_dirchange;
    logic             w_room;

    logic [WIDTH-1:0] r_dataout;
    logic             r_valid;
    logic             r_overrun;
    logic             r_frameerr;

    usr_sipo_core #(
        .WIDTH     (WIDTH)
    ) u_core (
        .clock     (clock),
        .reset     (reset),
        .mode      (mode),
        .serin     (serin),
        .servalid  (servalid),
        .done      (w_done),
        .word      (w_word),
        .dirchange (w_dirchange)
    );

    // The output slot is free if empty or being accepted this very edge.
    assign w_room = !r_valid || doutready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_dataout  <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
            r_frameerr <= 1'b0;
        end else begin
            if (w_done && w_room) begin
                r_dataout <= w_word;
                r_valid   <= 1'b1;
            end else if (r_valid && doutready) begin
                r_valid <= 1'b0;
            end

            if (w_done && !w_room) begin
                r_overrun <= 1'b1;
            end else if (clrerr) begin
                r_overrun <= 1'b0;
            end

            if (w_dirchange) begin
                r_frameerr <= 1'b1;
            end else if (clrerr) begin
                r_frameerr <= 1'b0;
            end
        end
    end

    assign dataout   = r_dataout;
    assign doutvalid = r_valid;
    assign overrun   = r_overrun;
    assign frameerr  = r_frameerr;

endmodule

`default_nettype wire

// File: tb/tb_usr_deserializer.sv
// ============================================================================
// Module  : tb_usr_deserializer
// Brief   : Directed self-checking bench for usr_deserializer, WIDTH=4.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_usr_deserializer;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic       serin;
    logic       servalid;
    logic [3:0] dataout;
    logic       doutvalid;
    logic       doutready;
    logic       overrun;
    logic       frameerr;
    logic       clrerr;

    int n_checks = 0;
    int n_fails  = 0;

    usr_deserializer #(
        .WIDTH     (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .mode      (mode),
        .serin     (serin),
        .servalid  (servalid),
        .dataout   (dataout),
        .doutvalid (doutvalid),
        .doutready (doutready),
        .overrun   (overrun),
        .frameerr  (frameerr),
        .clrerr    (clrerr)
    );

    always #5 clock = ~clock;

    // Apply inputs, then sample outputs 1 ns after the rising edge.
    task automatic step(input logic [1:0] m, input logic v, input logic s);
        mode     = m;
        servalid = v;
        serin    = s;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; mode = 2'b00; serin = 1'b0; servalid = 1'b0;
        doutready = 1'b0; clrerr = 1'b0;
        step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        reset = 1'b0;
        chk("reset_dataout", 32'(dataout), 32'h0);
        chk("reset_valid", 32'(doutvalid), 32'h0);
        chk("reset_overrun", 32'(overrun), 32'h0);
        chk("reset_frameerr", 32'(frameerr), 32'h0);

        // LSB-first 0,1,0,1 -> 4'hA
        step(2'b01, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b1);
        step(2'b01, 1'b1, 1'b0);
        chk("lsb_not_yet", 32'(doutvalid), 32'h0);
        step(2'b01, 1'b1, 1'b1);
        chk("lsb_data", 32'(dataout), 32'hA);
        chk("lsb_valid", 32'(doutvalid), 32'h1);
        chk("lsb_flags", {30'h0, overrun, frameerr}, 32'h0);
        doutready = 1'b1;
        step(2'b01, 1'b0, 1'b0);
        doutready = 1'b0;
        chk("accept_valid", 32'(doutvalid), 32'h0);
        chk("accept_hold", 32'(dataout), 32'hA);

        // MSB-first 1,0,(gap x2),1,1 -> 4'hB
        step(2'b10, 1'b1, 1'b1);
        step(2'b10, 1'b1, 1'b0);
        step(2'b10, 1'b0, 1'b1);
        step(2'b10, 1'b0, 1'b0);
        step(2'b10, 1'b1, 1'b1);
        chk("msb_gap_not_yet", 32'(doutvalid), 32'h0);
        step(2'b10, 1'b1, 1'b1);
        chk("msb_data", 32'(dataout), 32'hB);
        chk("msb_valid", 32'(doutvalid), 32'h1);
        chk("msb_no_frame", 32'(frameerr), 32'h0);
        doutready = 1'b1;
        step(2'b10, 1'b0, 1'b0);
        doutready = 1'b0;
        chk("msb_accept", 32'(doutvalid), 32'h0);

        // Back-to-back 0xA then 0x5 with no acceptance -> overrun
        step(2'b01, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b1);
        step(2'b01, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b1);
        chk("b2b_first", 32'(dataout), 32'hA);
        step(2'b01, 1'b1, 1'b1);
        step(2'b01, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b1);
        step(2'b01, 1'b1, 1'b0);
        chk("ovr_data_kept", 32'(dataout), 32'hA);
        chk("ovr_flag", 32'(overrun), 32'h1);
        chk("ovr_valid", 32'(doutvalid), 32'h1);
        clrerr = 1'b1;
        step(2'b01, 1'b0, 1'b0);
        clrerr = 1'b0;
        chk("ovr_clear", 32'(overrun), 32'h0);
        chk("ovr_still_valid", 32'(doutvalid), 32'h1);

        // 0x5 completing on the same edge as the accept of 0xA
        step(2'b01, 1'b1, 1'b1);
        step(2'b01, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b1);
        doutready = 1'b1;
        step(2'b01, 1'b1, 1'b0);
        chk("swap_data", 32'(dataout), 32'h5);
        chk("swap_valid", 32'(doutvalid), 32'h1);
        chk("swap_no_ovr", 32'(overrun), 32'h0);
        step(2'b01, 1'b0, 1'b0);
        doutready = 1'b0;
        chk("swap_accept", 32'(doutvalid), 32'h0);

        // Two LSB bits, then MSB-first 1,1,0,0 -> framing error, 4'hC
        step(2'b01, 1'b1, 1'b1);
        step(2'b01, 1'b1, 1'b1);
        step(2'b10, 1'b1, 1'b1);
        chk("frame_set", 32'(frameerr), 32'h1);
        chk("frame_no_word", 32'(doutvalid), 32'h0);
        step(2'b10, 1'b1, 1'b1);
        step(2'b10, 1'b1, 1'b0);
        step(2'b10, 1'b1, 1'b0);
        chk("frame_data", 32'(dataout), 32'hC);
        chk("frame_valid", 32'(doutvalid), 32'h1);
        doutready = 1'b1;
        clrerr    = 1'b1;
        step(2'b10, 1'b0, 1'b0);
        doutready = 1'b0;
        clrerr    = 1'b0;
        chk("frame_clear", 32'(frameerr), 32'h0);

        // Reset discards a partial word and clears the output port
        step(2'b01, 1'b1, 1'b1);
        step(2'b01, 1'b1, 1'b1);
        step(2'b01, 1'b1, 1'b1);
        reset = 1'b1;
        step(2'b01, 1'b1, 1'b1);
        reset = 1'b0;
        chk("rst2_dataout", 32'(dataout), 32'h0);
        chk("rst2_all", {29'h0, doutvalid, overrun, frameerr}, 32'h0);
        step(2'b01, 1'b1, 1'b0);
        chk("rst2_partial_gone", 32'(doutvalid), 32'h0);
        step(2'b01, 1'b1, 1'b1);
        step(2'b01, 1'b1, 1'b1);
        step(2'b01, 1'b1, 1'b0);
        chk("rst2_word", 32'(dataout), 32'h6);
        doutready = 1'b1;
        step(2'b01, 1'b0, 1'b0);
        doutready = 1'b0;

        // Hold after two bits, then resume in the same direction -> 4'hD
        step(2'b01, 1'b1, 1'b1);
        step(2'b01, 1'b1, 1'b0);
        step(2'b11, 1'b1, 1'b1);
        step(2'b11, 1'b0, 1'b1);
        step(2'b11, 1'b1, 1'b1);
        chk("hold_no_word", 32'(doutvalid), 32'h0);
        step(2'b01, 1'b1, 1'b1);
        step(2'b01, 1'b1, 1'b1);
        chk("hold_data", 32'(dataout), 32'hD);
        chk("hold_valid", 32'(doutvalid), 32'h1);
        chk("hold_no_frame", 32'(frameerr), 32'h0);
        doutready = 1'b1;
        step(2'b01, 1'b0, 1'b0);
        doutready = 1'b0;

        // Flush: MODE 00 drops the partial word, SERVALID ignored -> 4'hF
        step(2'b01, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b0);
        step(2'b00, 1'b1, 1'b0);
        step(2'b01, 1'b1, 1'b1);
        step(2'b01, 1'b1, 1'b1);
        step(2'b01, 1'b1, 1'b1);
        chk("flush_not_yet", 32'(doutvalid), 32'h0);
        step(2'b01, 1'b1, 1'b1);
        chk("flush_data", 32'(dataout), 32'hF);
        doutready = 1'b1;
        step(2'b01, 1'b0, 1'b0);
        doutready = 1'b0;

        // Direction change through hold, no bit sampled -> framing error
        step(2'b10, 1'b1, 1'b1);
        step(2'b11, 1'b0, 1'b0);
        chk("hold_dir_pre", 32'(frameerr), 32'h0);
        step(2'b01, 1'b0, 1'b0);
        chk("hold_dir_frame", 32'(frameerr), 32'h1);
        // Set wins over a simultaneous clear
        clrerr = 1'b1;
        step(2'b01, 1'b1, 1'b1);
        step(2'b10, 1'b1, 1'b1);
        clrerr = 1'b0;
        chk("set_wins", 32'(frameerr), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
